// File: rtl/bonus_timer_pkg.sv
// Shared types and register map for the bonus timer sequencer.
package bonus_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PAUSE   = 3'd2,
      ST_EXPIRED = 3'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_RELOAD = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_BONUS  = 2'd3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_PAUSE   = 1;
   localparam int CTRL_IRQ_CLR = 2;
   localparam int CTRL_AUTORLD = 3;

   localparam int STAT_STATE_LSB = 16;
   localparam int STAT_IRQ       = 24;
   localparam int STAT_WARN      = 25;

   function automatic logic [31:0] sat_bonus(input logic [63:0] p);
      return (|p[63:32]) ? 32'hFFFF_FFFF : p[31:0];
   endfunction

endpackage

// File: rtl/bonus_timer_ctrl_if.sv
// Register-shim side of the bonus timer: write strobe, read strobe, read return.
interface bonus_timer_ctrl_if;

   logic        reg_wr_en;
   logic [1:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic [3:0]  reg_wr_strb;
   logic        reg_rd_en;
   logic [1:0]  reg_rd_addr;
   logic [31:0] reg_rd_data;
   logic        reg_rd_valid;

   modport master (
      output reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb,
      output reg_rd_en, reg_rd_addr,
      input  reg_rd_data, reg_rd_valid
   );

   modport slave (
      input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb,
      input  reg_rd_en, reg_rd_addr,
      output reg_rd_data, reg_rd_valid
   );

endinterface

// File: rtl/bonus_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV enabled cycles; clr restarts.
module bonus_tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_pre;

   assign o_tick = i_en & ~i_clr & (r_pre == LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pre <= '0;
      end else if (i_clr) begin
         r_pre <= '0;
      end else if (i_en) begin
         r_pre <= (r_pre == LAST) ? '0 : r_pre + 1'b1;
      end
   end

endmodule

// File: rtl/bonus_timer_ctrl.sv
// Bonus window countdown, expiry irq and bonus capture for the pool game.
// Optional BONUS_TIMER_WARN_EN adds the warn_o blink output.
module bonus_timer_ctrl
   import bonus_timer_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TICK_DIV           = 100_000_000,
   parameter int CNT_W              = 16,
   parameter int BONUS_PER_SEC      = 10
`ifdef BONUS_TIMER_WARN_EN
   ,
   parameter int WARN_THRESH        = 5
`endif
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   bonus_timer_ctrl_if.slave    bus,
   input  logic                 game_start_i,
   input  logic                 ball_pocket_i,
   output logic [CNT_W-1:0]     count_o,
   output logic                 running_o,
   output logic                 irq_o
`ifdef BONUS_TIMER_WARN_EN
   ,
   output logic                 warn_o
`endif
);

   localparam int DW = C_S_AXI_DATA_WIDTH;

   state_t          r_state, w_nstate;
   logic [CNT_W-1:0] r_count, w_ncount;
   logic [DW-1:0]   r_reload, r_bonus, w_nbonus;
   logic [DW-1:0]   r_rd_data, w_rd_mux, w_status, w_ctrl_rd;
   logic            r_rd_valid, r_autoreload, r_irq;
   logic            w_irq_set, w_bonus_ld, w_tick, w_run, w_warn;
   logic            w_wr_ctrl, w_wr_reload, w_start, w_pause, w_irq_clr;
   logic [63:0]     w_prod;
   logic [CNT_W-1:0] w_reload_c;

   assign w_wr_ctrl   = bus.reg_wr_en & (bus.reg_wr_addr == ADDR_CTRL)
                      & bus.reg_wr_strb[0];
   assign w_wr_reload = bus.reg_wr_en & (bus.reg_wr_addr == ADDR_RELOAD);
   assign w_start     = game_start_i | (w_wr_ctrl & bus.reg_wr_data[CTRL_START]);
   assign w_pause     = w_wr_ctrl & bus.reg_wr_data[CTRL_PAUSE];
   assign w_irq_clr   = w_wr_ctrl & bus.reg_wr_data[CTRL_IRQ_CLR];
   assign w_run       = (r_state == ST_RUN);
   assign w_reload_c  = r_reload[CNT_W-1:0];
   assign w_prod      = 64'(r_count) * 64'(BONUS_PER_SEC);

   bonus_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .i_clk   (S_AXI_ACLK),
      .i_rst_n (S_AXI_ARESETN),
      .i_en    (w_run),
      .i_clr   (w_start),
      .o_tick  (w_tick)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) r_state <= ST_IDLE;
      else                r_state <= w_nstate;
   end

   // Priority: start, pocket, expiry, then ordinary tick/pause.
   always_comb begin
      w_nstate   = r_state;
      w_ncount   = r_count;
      w_irq_set  = 1'b0;
      w_bonus_ld = 1'b0;
      w_nbonus   = '0;
      if (w_start) begin
         w_nstate = ST_RUN;
         w_ncount = w_reload_c;
      end else if (ball_pocket_i) begin
         w_bonus_ld = 1'b1;
         if (w_run || r_state == ST_PAUSE) begin
            w_nstate = ST_IDLE;
            w_nbonus = sat_bonus(w_prod);
         end
      end else if (w_run && r_count == '0) begin
         w_nstate  = ST_EXPIRED;
         w_irq_set = 1'b1;
      end else if (w_run && w_tick && r_count == CNT_W'(1)) begin
         w_irq_set = 1'b1;
         if (r_autoreload) begin
            w_ncount = w_reload_c;
         end else begin
            w_ncount = '0;
            w_nstate = ST_EXPIRED;
         end
      end else begin
         if (w_run && w_tick) w_ncount = r_count - 1'b1;
         if (w_pause && w_run)                 w_nstate = ST_PAUSE;
         else if (w_pause && r_state == ST_PAUSE) w_nstate = ST_RUN;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_count      <= '0;
         r_irq        <= 1'b0;
         r_bonus      <= '0;
         r_reload     <= '0;
         r_autoreload <= 1'b0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_count    <= w_ncount;
         r_irq      <= w_irq_set | (r_irq & ~w_irq_clr);
         r_rd_valid <= bus.reg_rd_en;
         if (w_bonus_ld)    r_bonus <= w_nbonus;
         if (w_wr_ctrl)     r_autoreload <= bus.reg_wr_data[CTRL_AUTORLD];
         if (bus.reg_rd_en) r_rd_data <= w_rd_mux;
         for (int b = 0; b < 4; b++) begin
            if (w_wr_reload && bus.reg_wr_strb[b])
               r_reload[8*b +: 8] <= bus.reg_wr_data[8*b +: 8];
         end
      end
   end

`ifdef BONUS_TIMER_WARN_EN
   logic r_warn;

   // Phase flips on each tick that lands inside the window, so it blinks at 0.5 Hz.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_warn <= 1'b0;
      end else if (w_start) begin
         r_warn <= 1'b0;
      end else if (w_run && w_tick) begin
         r_warn <= (w_ncount != '0 && w_ncount <= CNT_W'(WARN_THRESH))
                 ? ~r_warn : 1'b0;
      end
   end

   assign w_warn = r_warn & w_run & (r_count != '0)
                 & (r_count <= CNT_W'(WARN_THRESH));
   assign warn_o = w_warn;
`else
   assign w_warn = 1'b0;
`endif

   always_comb begin
      w_status                       = '0;
      w_status[CNT_W-1:0]            = r_count;
      w_status[STAT_STATE_LSB +: 3]  = r_state;
      w_status[STAT_IRQ]             = r_irq;
      w_status[STAT_WARN]            = w_warn;
      w_ctrl_rd                      = '0;
      w_ctrl_rd[CTRL_AUTORLD]        = r_autoreload;
      w_rd_mux                       = '0;
      unique case (bus.reg_rd_addr)
         ADDR_CTRL:   w_rd_mux = w_ctrl_rd;
         ADDR_RELOAD: w_rd_mux = r_reload;
         ADDR_STATUS: w_rd_mux = w_status;
         ADDR_BONUS:  w_rd_mux = r_bonus;
      endcase
   end

   assign bus.reg_rd_data  = r_rd_data;
   assign bus.reg_rd_valid = r_rd_valid;
   assign count_o          = r_count;
   assign running_o        = w_run;
   assign irq_o            = r_irq;

endmodule

// File: tb/tb_bonus_timer_ctrl.sv
// Directed vector bench for bonus_timer_ctrl with TICK_DIV=4, CNT_W=16.
module tb_bonus_timer_ctrl;
   import bonus_timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gs = 1'b0;
   logic        bp = 1'b0;
   logic [15:0] cnt;
   logic        run, irq;
`ifdef BONUS_TIMER_WARN_EN
   logic        warn;
`endif

   bonus_timer_ctrl_if bif ();

   always #5 clk = ~clk;

   bonus_timer_ctrl #(.TICK_DIV(4), .CNT_W(16)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .bus           (bif),
      .game_start_i  (gs),
      .ball_pocket_i (bp),
      .count_o       (cnt),
      .running_o     (run),
      .irq_o         (irq)
`ifdef BONUS_TIMER_WARN_EN
      ,
      .warn_o        (warn)
`endif
   );

   typedef struct {
      logic        we;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic        re;
      logic [1:0]  ra;
      logic        gs;
      logic        bp;
      int          idle;
      logic [15:0] ecnt;
      logic        erun;
      logic        eirq;
      logic [31:0] erd;
   } vec_t;

   vec_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(logic we, logic [1:0] wa, logic [31:0] wd,
                               logic [3:0] ws, logic re, logic [1:0] ra,
                               logic g, logic b, int idle, logic [15:0] c,
                               logic r, logic i, logic [31:0] rd);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ws = ws; v.re = re; v.ra = ra;
      v.gs = g; v.bp = b; v.idle = idle; v.ecnt = c; v.erun = r;
      v.eirq = i; v.erd = rd;
      return v;
   endfunction

   function automatic vec_t wr(logic [1:0] a, logic [31:0] d, logic [3:0] s,
                               logic [15:0] c, logic r, logic i);
      return mk(1'b1, a, d, s, 1'b0, 2'd0, 1'b0, 1'b0, 0, c, r, i, 32'd0);
   endfunction

   function automatic vec_t rd(logic [1:0] a, logic [31:0] e,
                               logic [15:0] c, logic r, logic i);
      return mk(1'b0, 2'd0, 32'd0, 4'd0, 1'b1, a, 1'b0, 1'b0, 0, c, r, i, e);
   endfunction

   function automatic vec_t id(int n, logic [15:0] c, logic r, logic i);
      return mk(1'b0, 2'd0, 32'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, n, c, r, i, 32'd0);
   endfunction

   function automatic vec_t ev(logic g, logic b, logic [15:0] c, logic r, logic i);
      return mk(1'b0, 2'd0, 32'd0, 4'd0, 1'b0, 2'd0, g, b, 0, c, r, i, 32'd0);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic drive_idle();
      bif.reg_wr_en = 1'b0; bif.reg_wr_addr = 2'd0; bif.reg_wr_data = 32'd0;
      bif.reg_wr_strb = 4'd0; bif.reg_rd_en = 1'b0; bif.reg_rd_addr = 2'd0;
      gs = 1'b0; bp = 1'b0;
   endtask

   // Called at a negedge: drive for one edge, idle v.idle edges, check at negedge.
   task automatic apply(vec_t v, string tag);
      bif.reg_wr_en = v.we; bif.reg_wr_addr = v.wa; bif.reg_wr_data = v.wd;
      bif.reg_wr_strb = v.ws; bif.reg_rd_en = v.re; bif.reg_rd_addr = v.ra;
      gs = v.gs; bp = v.bp;
      @(posedge clk);
      #1 drive_idle();
      repeat (v.idle) @(posedge clk);
      @(negedge clk);
      chk({tag, ".cnt"}, 32'(cnt), 32'(v.ecnt));
      chk({tag, ".run"}, 32'(run), 32'(v.erun));
      chk({tag, ".irq"}, 32'(irq), 32'(v.eirq));
      if (v.re) begin
         chk({tag, ".rvalid"}, 32'(bif.reg_rd_valid), 32'd1);
         chk({tag, ".rdata"}, bif.reg_rd_data, v.erd);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      drive_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.cnt", 32'(cnt), 32'd0);
      chk("rst.run", 32'(run), 32'd0);
      chk("rst.irq", 32'(irq), 32'd0);
      chk("rst.rvalid", 32'(bif.reg_rd_valid), 32'd0);
      chk("rst.rdata", bif.reg_rd_data, 32'd0);
      rst_n = 1'b1;

      // countdown to expiry
      q.push_back(wr(ADDR_RELOAD, 32'd3, 4'hF, 16'd0, 1'b0, 1'b0));
      q.push_back(wr(ADDR_CTRL, 32'h1, 4'hF, 16'd3, 1'b1, 1'b0));
      q.push_back(id(3, 16'd2, 1'b1, 1'b0));
      q.push_back(id(3, 16'd1, 1'b1, 1'b0));
      q.push_back(id(3, 16'd0, 1'b0, 1'b1));
      q.push_back(rd(ADDR_STATUS, 32'h0103_0000, 16'd0, 1'b0, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'h4, 4'hF, 16'd0, 1'b0, 1'b0));
      // pause / resume
      q.push_back(wr(ADDR_CTRL, 32'h1, 4'hF, 16'd3, 1'b1, 1'b0));
      q.push_back(id(3, 16'd2, 1'b1, 1'b0));
      q.push_back(wr(ADDR_CTRL, 32'h2, 4'hF, 16'd2, 1'b0, 1'b0));
      q.push_back(id(19, 16'd2, 1'b0, 1'b0));
      q.push_back(rd(ADDR_STATUS, 32'h0002_0002, 16'd2, 1'b0, 1'b0));
      q.push_back(wr(ADDR_CTRL, 32'h2, 4'hF, 16'd2, 1'b1, 1'b0));
      q.push_back(id(2, 16'd1, 1'b1, 1'b0));
      q.push_back(id(3, 16'd0, 1'b0, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'h4, 4'hF, 16'd0, 1'b0, 1'b0));
      // hardware start, pocket at count 4
      q.push_back(wr(ADDR_RELOAD, 32'd7, 4'hF, 16'd0, 1'b0, 1'b0));
      q.push_back(ev(1'b1, 1'b0, 16'd7, 1'b1, 1'b0));
      q.push_back(id(3, 16'd6, 1'b1, 1'b0));
      q.push_back(id(3, 16'd5, 1'b1, 1'b0));
      q.push_back(id(3, 16'd4, 1'b1, 1'b0));
      q.push_back(ev(1'b0, 1'b1, 16'd4, 1'b0, 1'b0));
      q.push_back(rd(ADDR_BONUS, 32'd40, 16'd4, 1'b0, 1'b0));
      q.push_back(rd(ADDR_STATUS, 32'h0000_0004, 16'd4, 1'b0, 1'b0));
      q.push_back(ev(1'b0, 1'b1, 16'd4, 1'b0, 1'b0));
      q.push_back(rd(ADDR_BONUS, 32'd0, 16'd4, 1'b0, 1'b0));
      // autoreload, irq clear, expiry beats irq clear
      q.push_back(wr(ADDR_RELOAD, 32'd2, 4'hF, 16'd4, 1'b0, 1'b0));
      q.push_back(wr(ADDR_CTRL, 32'h9, 4'hF, 16'd2, 1'b1, 1'b0));
      q.push_back(rd(ADDR_CTRL, 32'h8, 16'd2, 1'b1, 1'b0));
      q.push_back(id(2, 16'd1, 1'b1, 1'b0));
      q.push_back(id(3, 16'd2, 1'b1, 1'b1));
      q.push_back(id(3, 16'd1, 1'b1, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'hC, 4'hF, 16'd1, 1'b1, 1'b0));
      q.push_back(id(2, 16'd2, 1'b1, 1'b1));
      q.push_back(id(2, 16'd2, 1'b1, 1'b1));
      q.push_back(id(0, 16'd1, 1'b1, 1'b1));
      q.push_back(id(2, 16'd1, 1'b1, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'hC, 4'hF, 16'd2, 1'b1, 1'b1));
      // reload 0: start then expire on the next edge
      q.push_back(wr(ADDR_CTRL, 32'h0, 4'h1, 16'd2, 1'b1, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'h4, 4'hF, 16'd2, 1'b1, 1'b0));
      q.push_back(wr(ADDR_RELOAD, 32'd0, 4'hF, 16'd2, 1'b1, 1'b0));
      q.push_back(wr(ADDR_CTRL, 32'h1, 4'hF, 16'd0, 1'b1, 1'b0));
      q.push_back(id(0, 16'd0, 1'b0, 1'b1));
      // byte strobes, ignored writes
      q.push_back(wr(ADDR_RELOAD, 32'h1234, 4'h1, 16'd0, 1'b0, 1'b1));
      q.push_back(rd(ADDR_RELOAD, 32'h34, 16'd0, 1'b0, 1'b1));
      q.push_back(wr(ADDR_STATUS, 32'hFFFF_FFFF, 4'hF, 16'd0, 1'b0, 1'b1));
      q.push_back(rd(ADDR_STATUS, 32'h0103_0000, 16'd0, 1'b0, 1'b1));
      q.push_back(wr(ADDR_CTRL, 32'h1, 4'h2, 16'd0, 1'b0, 1'b1));
      // start beats pocket, then pocket captures 5*10
      q.push_back(wr(ADDR_RELOAD, 32'd5, 4'hF, 16'd0, 1'b0, 1'b1));
      q.push_back(ev(1'b1, 1'b1, 16'd5, 1'b1, 1'b1));
      q.push_back(ev(1'b0, 1'b1, 16'd5, 1'b0, 1'b1));
      q.push_back(rd(ADDR_BONUS, 32'd50, 16'd5, 1'b0, 1'b1));

      for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("v%0d", i));

      // reset in the middle of a run
      apply(wr(ADDR_CTRL, 32'h1, 4'hF, 16'd5, 1'b1, 1'b1), "mr0");
      apply(id(5, 16'd4, 1'b1, 1'b1), "mr1");
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mr.cnt", 32'(cnt), 32'd0);
      chk("mr.run", 32'(run), 32'd0);
      chk("mr.irq", 32'(irq), 32'd0);
      chk("mr.rdata", bif.reg_rd_data, 32'd0);
      rst_n = 1'b1;
      apply(rd(ADDR_RELOAD, 32'd0, 16'd0, 1'b0, 1'b0), "mr2");
      apply(rd(ADDR_BONUS, 32'd0, 16'd0, 1'b0, 1'b0), "mr3");
      apply(rd(ADDR_STATUS, 32'd0, 16'd0, 1'b0, 1'b0), "mr4");
      apply(id(8, 16'd0, 1'b0, 1'b0), "mr5");

`ifdef BONUS_TIMER_WARN_EN
      apply(wr(ADDR_RELOAD, 32'd6, 4'hF, 16'd0, 1'b0, 1'b0), "w0");
      apply(wr(ADDR_CTRL, 32'h1, 4'hF, 16'd6, 1'b1, 1'b0), "w1");
      chk("w.c6", 32'(warn), 32'd0);
      for (int k = 5; k >= 0; k--) begin
         apply(id(3, 16'(k), k != 0, k == 0), $sformatf("w.c%0d", k));
         chk($sformatf("w.warn%0d", k), 32'(warn), 32'(k % 2));
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
